// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared state encoding, address width and pointer arithmetic
// for the memory copy engine.
package mem_copy_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The 8-bit result wraps past 0xFF back to 0x00.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr,
                                                 input logic [ADDR_W-1:0] step);
    return ptr + step;
  endfunction

endpackage

// File: rtl/mem_copy_ptr.sv
// rtl/mem_copy_ptr.sv - 8-bit byte pointer with load and increment-by-STEP, async clear.
// Exposes its next value so the owner can register addresses in the same cycle.
module mem_copy_ptr
  import mem_copy_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr,
  output logic [ADDR_W-1:0] o_ptr_nxt
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  logic [ADDR_W-1:0] r_ptr;

  always_comb begin
    o_ptr_nxt = r_ptr;
    if (i_load) begin
      o_ptr_nxt = i_load_val;
    end else if (i_inc) begin
      o_ptr_nxt = next_ptr(r_ptr, STEP_V);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= o_ptr_nxt;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - single-port block copy master (read word, write word, repeat).
// Optional constant-fill mode is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill_i,
  input  logic [W-1:0]      fill_data_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wrt_enable,
  output logic [W-1:0]      mem_wrt_data,
  input  logic [W-1:0]      mem_read_data
);

  localparam int BYTES = W / 8;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]      r_hold, w_hold_nxt;
  logic              r_fill, w_fill_nxt;
  logic              w_fill_req;
  logic [W-1:0]      w_fill_val;
  logic              w_src_ld, w_src_inc, w_dst_ld, w_dst_inc;
  logic [ADDR_W-1:0] w_src, w_src_nxt, w_dst, w_dst_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_wen, w_wen_nxt;
  logic [W-1:0]      r_wdata, w_wdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

`ifdef MEM_COPY_FILL_EN
  assign w_fill_req = fill_i;
  assign w_fill_val = fill_data_i;
`else
  assign w_fill_req = 1'b0;
  assign w_fill_val = '0;
`endif

  mem_copy_ptr #(.STEP(BYTES)) u_src_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_src_ld),
    .i_load_val (src_i),
    .i_inc      (w_src_inc),
    .o_ptr      (w_src),
    .o_ptr_nxt  (w_src_nxt)
  );

  mem_copy_ptr #(.STEP(BYTES)) u_dst_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_dst_ld),
    .i_load_val (dst_i),
    .i_inc      (w_dst_inc),
    .o_ptr      (w_dst),
    .o_ptr_nxt  (w_dst_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_fill_nxt  = r_fill;
    w_src_ld    = 1'b0;
    w_src_inc   = 1'b0;
    w_dst_ld    = 1'b0;
    w_dst_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_src_ld   = 1'b1;
          w_dst_ld   = 1'b1;
          w_cnt_nxt  = len_i;
          w_fill_nxt = w_fill_req;
          if (w_fill_req) w_hold_nxt = w_fill_val;
          if (len_i == '0)     w_state_nxt = DONE;
          else if (w_fill_req) w_state_nxt = WRITE;
          else                 w_state_nxt = READ;
        end
      end
      READ: begin
        w_hold_nxt  = mem_read_data;
        w_src_inc   = 1'b1;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        w_dst_inc = 1'b1;
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) w_state_nxt = DONE;
        else if (r_fill)   w_state_nxt = WRITE;
        else               w_state_nxt = READ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory outputs are decoded from the state being entered so they are valid right at the edge.
  always_comb begin
    w_addr_nxt  = '0;
    w_wen_nxt   = 1'b0;
    w_wdata_nxt = '0;
    w_done_nxt  = (w_state_nxt == DONE);
    w_busy_nxt  = (w_state_nxt == READ) || (w_state_nxt == WRITE) ||
                  ((w_state_nxt == DONE) && (r_state != IDLE));
    case (w_state_nxt)
      READ:  w_addr_nxt = w_src_nxt;
      WRITE: begin
        w_addr_nxt  = w_dst_nxt;
        w_wen_nxt   = 1'b1;
        w_wdata_nxt = w_hold_nxt;
      end
      default: w_addr_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_fill  <= 1'b0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_fill  <= w_fill_nxt;
      r_addr  <= w_addr_nxt;
      r_wen   <= w_wen_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign mem_address    = r_addr;
  assign mem_wrt_enable = r_wen;
  assign mem_wrt_data   = r_wdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine with W=8 and W=16 instances.
module tb_mem_copy_engine;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  wr_t  q[$];

  logic        start8, busy8, done8, wen8;
  logic [7:0]  src8, dst8, len8, addr8, wdata8, rdata8;
  logic        fill8;
  logic [7:0]  fdata8;

  logic        start16, busy16, done16, wen16;
  logic [7:0]  src16, dst16, len16, addr16, a16p1;
  logic [15:0] wdata16, rdata16;
  logic        fill16;
  logic [15:0] fdata16;

  logic [7:0]  mem8  [0:255];
  logic [7:0]  mem16 [0:255];
  logic        pl_we, pl_sel;
  logic [7:0]  pl_addr, pl_data;

  mem_copy_engine #(.W(8)) u_dut8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start8),
    .src_i          (src8),
    .dst_i          (dst8),
    .len_i          (len8),
`ifdef MEM_COPY_FILL_EN
    .fill_i         (fill8),
    .fill_data_i    (fdata8),
`endif
    .busy_o         (busy8),
    .done_o         (done8),
    .mem_address    (addr8),
    .mem_wrt_enable (wen8),
    .mem_wrt_data   (wdata8),
    .mem_read_data  (rdata8)
  );

  mem_copy_engine #(.W(16)) u_dut16 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start16),
    .src_i          (src16),
    .dst_i          (dst16),
    .len_i          (len16),
`ifdef MEM_COPY_FILL_EN
    .fill_i         (fill16),
    .fill_data_i    (fdata16),
`endif
    .busy_o         (busy16),
    .done_o         (done16),
    .mem_address    (addr16),
    .mem_wrt_enable (wen16),
    .mem_wrt_data   (wdata16),
    .mem_read_data  (rdata16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a16p1   = addr16 + 8'd1;
  assign rdata8  = mem8[addr8];
  assign rdata16 = {mem16[a16p1], mem16[addr16]};

  always @(posedge clk) begin
    if (pl_we && !pl_sel)  mem8[pl_addr] <= pl_data;
    else if (wen8)         mem8[addr8] <= wdata8;
    if (pl_we && pl_sel)   mem16[pl_addr] <= pl_data;
    else if (wen16) begin
      mem16[addr16] <= wdata16[7:0];
      mem16[a16p1]  <= wdata16[15:8];
    end
  end

  task automatic preload(input logic sel, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_sel = sel; pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy8, done8, addr8, wen8, wdata8} !== 19'd0) begin
      n_fail++; $display("FAIL reset_w8 got=%h exp=0", {busy8, done8, addr8, wen8, wdata8});
    end
    n_checks++;
    if ({busy16, done16, addr16, wen16, wdata16} !== 27'd0) begin
      n_fail++; $display("FAIL reset_w16 got=%h exp=0", {busy16, done16, addr16, wen16, wdata16});
    end
  endtask

  task automatic test_copy4();
    int done_k, n_done, busy_err;
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      preload(1'b0, 8'(8'h10 + i), 8'(8'hA1 + i));
      preload(1'b0, 8'(8'h80 + i), 8'h00);
      e.a = 8'(8'h80 + i); e.d = 16'(8'hA1 + i); q.push_back(e);
    end
    @(negedge clk); start8 = 1'b1; src8 = 8'h10; dst8 = 8'h80; len8 = 8'd4;
    @(negedge clk); start8 = 1'b0;
    done_k = 0; n_done = 0; busy_err = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (done8) begin n_done++; if (done_k == 0) done_k = k; end
      if (busy8 !== (k <= 9)) busy_err++;
      if (wen8) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL copy4_extra_write addr=%h exp=none", addr8); end
        else begin
          e = q.pop_front();
          if (addr8 !== e.a || wdata8 !== e.d[7:0]) begin
            n_fail++; $display("FAIL copy4_write got=%h/%h exp=%h/%h", addr8, wdata8, e.a, e.d[7:0]);
          end
        end
      end
    end
    n_checks++; if (done_k != 9) begin n_fail++; $display("FAIL copy4_done_cycle got=%0d exp=9", done_k); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL copy4_done_count got=%0d exp=1", n_done); end
    n_checks++; if (busy_err != 0) begin n_fail++; $display("FAIL copy4_busy got=%0d_bad_cycles exp=0", busy_err); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL copy4_missing_writes got=%0d exp=0", q.size()); q.delete(); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem8[8'(8'h80 + i)] !== 8'(8'hA1 + i)) begin
        n_fail++; $display("FAIL copy4_mem[%0d] got=%h exp=%h", i, mem8[8'(8'h80 + i)], 8'(8'hA1 + i));
      end
    end
  endtask

  task automatic test_zero_len();
    int done_k, n_wen, n_busy;
    preload(1'b0, 8'hB0, 8'h77);
    @(negedge clk); start8 = 1'b1; src8 = 8'h10; dst8 = 8'hB0; len8 = 8'd0;
    @(negedge clk); start8 = 1'b0;
    done_k = 0; n_wen = 0; n_busy = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (done8 && done_k == 0) done_k = k;
      if (wen8) n_wen++;
      if (busy8) n_busy++;
    end
    n_checks++; if (done_k != 1) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=1", done_k); end
    n_checks++; if (n_wen != 0) begin n_fail++; $display("FAIL zero_writes got=%0d exp=0", n_wen); end
    n_checks++; if (n_busy != 0) begin n_fail++; $display("FAIL zero_busy got=%0d exp=0", n_busy); end
    n_checks++; if (mem8[8'hB0] !== 8'h77) begin n_fail++; $display("FAIL zero_mem got=%h exp=77", mem8[8'hB0]); end
  endtask

  task automatic test_wrap16();
    int done_k;
    logic [31:0] addrs;
    wr_t e;
    preload(1'b1, 8'hFE, 8'h11); preload(1'b1, 8'hFF, 8'h22);
    preload(1'b1, 8'h00, 8'h33); preload(1'b1, 8'h01, 8'h44);
    for (int i = 0; i < 4; i++) preload(1'b1, 8'(8'h40 + i), 8'h00);
    e.a = 8'h40; e.d = 16'h2211; q.push_back(e);
    e.a = 8'h42; e.d = 16'h4433; q.push_back(e);
    @(negedge clk); start16 = 1'b1; src16 = 8'hFE; dst16 = 8'h40; len16 = 8'd2;
    @(negedge clk); start16 = 1'b0;
    done_k = 0; addrs = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 4) addrs = {addrs[23:0], addr16};
      if (done16 && done_k == 0) done_k = k;
      if (wen16) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL wrap_extra_write addr=%h exp=none", addr16); end
        else begin
          e = q.pop_front();
          if (addr16 !== e.a || wdata16 !== e.d) begin
            n_fail++; $display("FAIL wrap_write got=%h/%h exp=%h/%h", addr16, wdata16, e.a, e.d);
          end
        end
      end
    end
    n_checks++; if (addrs !== 32'hFE40_0042) begin n_fail++; $display("FAIL wrap_addrs got=%h exp=fe400042", addrs); end
    n_checks++; if (done_k != 5) begin n_fail++; $display("FAIL wrap_done_cycle got=%0d exp=5", done_k); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL wrap_missing_writes got=%0d exp=0", q.size()); q.delete(); end
    n_checks++;
    if ({mem16[8'h40], mem16[8'h41], mem16[8'h42], mem16[8'h43]} !== 32'h1122_3344) begin
      n_fail++; $display("FAIL wrap_mem got=%h exp=11223344",
                         {mem16[8'h40], mem16[8'h41], mem16[8'h42], mem16[8'h43]});
    end
  endtask

  task automatic test_ignore_start();
    int done_k, n_done;
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      preload(1'b0, 8'(8'h90 + i), 8'h00);
      e.a = 8'(8'h90 + i); e.d = 16'(8'hA1 + i); q.push_back(e);
    end
    preload(1'b0, 8'hA0, 8'h55);
    @(negedge clk); start8 = 1'b1; src8 = 8'h10; dst8 = 8'h90; len8 = 8'd4;
    @(negedge clk); start8 = 1'b0;
    done_k = 0; n_done = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) begin start8 = 1'b1; src8 = 8'h20; dst8 = 8'hA0; len8 = 8'd2; end
      if (k == 4) start8 = 1'b0;
      if (done8) begin n_done++; if (done_k == 0) done_k = k; end
      if (wen8) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL ignore_extra_write addr=%h exp=none", addr8); end
        else begin
          e = q.pop_front();
          if (addr8 !== e.a || wdata8 !== e.d[7:0]) begin
            n_fail++; $display("FAIL ignore_write got=%h/%h exp=%h/%h", addr8, wdata8, e.a, e.d[7:0]);
          end
        end
      end
    end
    n_checks++; if (done_k != 9 || n_done != 1) begin n_fail++; $display("FAIL ignore_done got=%0d/%0d exp=9/1", done_k, n_done); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL ignore_missing_writes got=%0d exp=0", q.size()); q.delete(); end
    n_checks++; if (mem8[8'hA0] !== 8'h55) begin n_fail++; $display("FAIL ignore_second_dst got=%h exp=55", mem8[8'hA0]); end
  endtask

  task automatic test_back_to_back();
    int done_a, done_b, busy_k4;
    wr_t e;
    preload(1'b0, 8'hC0, 8'h00);
    e.a = 8'hC0; e.d = 16'h00A3; q.push_back(e); q.push_back(e);
    @(negedge clk); start8 = 1'b1; src8 = 8'h12; dst8 = 8'hC0; len8 = 8'd1;
    @(negedge clk);
    done_a = 0; done_b = 0; busy_k4 = -1;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) start8 = 1'b0;
      if (k == 4) busy_k4 = int'(busy8);
      if (done8) begin if (done_a == 0) done_a = k; else if (done_b == 0) done_b = k; end
      if (wen8) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL b2b_extra_write addr=%h exp=none", addr8); end
        else begin
          e = q.pop_front();
          if (addr8 !== e.a || wdata8 !== e.d[7:0]) begin
            n_fail++; $display("FAIL b2b_write got=%h/%h exp=%h/%h", addr8, wdata8, e.a, e.d[7:0]);
          end
        end
      end
    end
    n_checks++; if (done_a != 3 || done_b != 7) begin n_fail++; $display("FAIL b2b_done got=%0d,%0d exp=3,7", done_a, done_b); end
    n_checks++; if (busy_k4 != 0) begin n_fail++; $display("FAIL b2b_idle_busy got=%0d exp=0", busy_k4); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_writes got=%0d exp=0", q.size()); q.delete(); end
    n_checks++; if (mem8[8'hC0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_mem got=%h exp=a3", mem8[8'hC0]); end
  endtask

`ifdef MEM_COPY_FILL_EN
  task automatic test_fill();
    int done_k;
    wr_t e;
    for (int i = 0; i < 3; i++) begin
      preload(1'b0, 8'(8'h20 + i), 8'h00);
      e.a = 8'(8'h20 + i); e.d = 16'h005A; q.push_back(e);
    end
    preload(1'b0, 8'h23, 8'hEE);
    @(negedge clk); start8 = 1'b1; fill8 = 1'b1; fdata8 = 8'h5A; src8 = 8'h10; dst8 = 8'h20; len8 = 8'd3;
    @(negedge clk); start8 = 1'b0; fill8 = 1'b0; fdata8 = 8'h00;
    done_k = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (done8 && done_k == 0) done_k = k;
      if (wen8) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL fill_extra_write addr=%h exp=none", addr8); end
        else begin
          e = q.pop_front();
          if (addr8 !== e.a || wdata8 !== e.d[7:0]) begin
            n_fail++; $display("FAIL fill_write got=%h/%h exp=%h/%h", addr8, wdata8, e.a, e.d[7:0]);
          end
        end
      end
    end
    n_checks++; if (done_k != 4) begin n_fail++; $display("FAIL fill_done_cycle got=%0d exp=4", done_k); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL fill_missing_writes got=%0d exp=0", q.size()); q.delete(); end
    n_checks++; if (mem8[8'h23] !== 8'hEE) begin n_fail++; $display("FAIL fill_overrun got=%h exp=ee", mem8[8'h23]); end
  endtask
`endif

  task automatic test_reset_mid();
    int n_done, n_wen, n_bad;
    wr_t e;
    for (int i = 0; i < 8; i++) begin
      preload(1'b0, 8'(8'h10 + i), 8'(8'hA1 + i));
      preload(1'b0, 8'(8'hD0 + i), 8'hEE);
    end
    for (int i = 0; i < 3; i++) begin
      e.a = 8'(8'hD0 + i); e.d = 16'(8'hA1 + i); q.push_back(e);
    end
    @(negedge clk); start8 = 1'b1; src8 = 8'h10; dst8 = 8'hD0; len8 = 8'd8;
    @(negedge clk); start8 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (wen8) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rstmid_extra_write addr=%h exp=none", addr8); end
        else begin
          e = q.pop_front();
          if (addr8 !== e.a || wdata8 !== e.d[7:0]) begin
            n_fail++; $display("FAIL rstmid_write got=%h/%h exp=%h/%h", addr8, wdata8, e.a, e.d[7:0]);
          end
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, addr8, wen8, wdata8} !== 19'd0) begin
      n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", {busy8, done8, addr8, wen8, wdata8});
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    n_done = 0; n_wen = 0; n_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8) n_done++;
      if (wen8) n_wen++;
    end
    for (int i = 2; i < 8; i++) if (mem8[8'(8'hD0 + i)] !== 8'hEE) n_bad++;
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_done got=%0d exp=0", n_done); end
    n_checks++; if (n_wen != 0) begin n_fail++; $display("FAIL rstmid_late_writes got=%0d exp=0", n_wen); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rstmid_missing_writes got=%0d exp=0", q.size()); q.delete(); end
    n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL rstmid_mem_tail got=%0d_changed exp=0", n_bad); end
    n_checks++;
    if ({mem8[8'hD0], mem8[8'hD1]} !== 16'hA1A2) begin
      n_fail++; $display("FAIL rstmid_mem_head got=%h exp=a1a2", {mem8[8'hD0], mem8[8'hD1]});
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    pl_we = 1'b0; pl_sel = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    start8 = 1'b0; src8 = 8'h00; dst8 = 8'h00; len8 = 8'h00; fill8 = 1'b0; fdata8 = 8'h00;
    start16 = 1'b0; src16 = 8'h00; dst16 = 8'h00; len16 = 8'h00; fill16 = 1'b0; fdata16 = 16'h0000;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_copy4();
    test_zero_len();
    test_wrap16();
    test_ignore_start();
    test_back_to_back();
`ifdef MEM_COPY_FILL_EN
    test_fill();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
